ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 201 ++++++++++++++++++++
 tb/tb_ifetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch unit with a small in-order prefetch queue.
// Fetches from a local single-cycle IMEM when the address lies inside it,
// otherwise from an external port with a variable-latency handshake.
// A redirect (br_en) flushes the queue and restarts fetching at br_addr.
module ifetch_queue #(
    parameter logic [31:0] PC_INIT     = 32'h0000_00fc,
    parameter int          IMEM_AWIDTH = 11,
    parameter int          QDEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   stall,
    input  logic                   br_en,
    input  logic [31:0]            br_addr,
    output logic                   ins_valid,
    output logic [31:0]            ins_out,
    output logic [31:0]            ins_pc,
    output logic                   imem_ren,
    output logic [IMEM_AWIDTH-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   exIns_ren,
    output logic [31:0]            exIns_addr,
    input  logic                   exIns_valid,
    input  logic [31:0]            exIns_in
);

    localparam int          PTR_W      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [31:0] IMEM_SIZE  = 32'(2 ** IMEM_AWIDTH);
    localparam logic [31:0] LOCAL_LAST = IMEM_SIZE - 32'd4;
    localparam logic [31:0] EX_IDLE    = 32'hffff_ffff;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        EXWAIT  = 2'd1,
        EXDRAIN = 2'd2
    } state_t;

    // Fetch control state
    state_t       state_q;
    logic [31:0]  fetch_pc_q;
    logic         go_q;          // low for the first cycle after reset so no fetch issues then
    logic         inflight_q;    // a local IMEM read is returning this cycle
    logic [31:0]  lpc_q;         // address of the outstanding local read
    logic         exren_q;
    logic [31:0]  exaddr_q;

    // Queue storage and pointers
    logic [31:0]      pc_arr  [QDEPTH];
    logic [31:0]      ins_arr [QDEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    // Combinational decisions
    logic [CNT_W:0] occ;
    logic           room;
    logic           is_local;
    logic           can_fetch;
    logic           issue_local;
    logic           start_ext;
    logic           push_local;
    logic           push_ext;
    logic           push;
    logic           pop;
    logic [31:0]    push_pc;
    logic [31:0]    push_ins;
    logic [31:0]    redirect_pc;
    logic [31:0]    ex_target;

    // Issue/push/pop decisions for the current cycle
    always_comb begin
        occ         = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        room        = occ < (CNT_W + 1)'(QDEPTH);
        is_local    = fetch_pc_q <= LOCAL_LAST;
        redirect_pc = br_addr & ~32'h0000_0003;
        ex_target   = fetch_pc_q - IMEM_SIZE;

        // A redirect suppresses any issue at the stale fetch_pc.
        can_fetch   = go_q && (state_q == RUN) && !br_en && room;
        issue_local = can_fetch && is_local;
        // Crossing into external space waits until the local read has landed,
        // keeping responses in program order.
        start_ext   = can_fetch && !is_local && !inflight_q;

        // A redirect empties the queue on the same edge the local response
        // would be written, so that response is simply not pushed.
        push_local  = inflight_q && !br_en;
        push_ext    = (state_q == EXWAIT) && exIns_valid && !br_en;
        push        = push_local || push_ext;
        push_pc     = push_ext ? fetch_pc_q : lpc_q;
        push_ins    = push_ext ? exIns_in   : imem_rdata;

        pop         = ins_valid && !stall && !br_en;
    end

    // Output views of the queue head and the fetch ports
    always_comb begin
        ins_valid  = (count_q != '0);
        ins_out    = ins_valid ? ins_arr[head_q] : 32'd0;
        ins_pc     = ins_valid ? pc_arr[head_q]  : 32'd0;
        imem_ren   = issue_local;
        imem_addr  = issue_local ? fetch_pc_q[IMEM_AWIDTH-1:0] : '0;
        exIns_ren  = exren_q;
        exIns_addr = exaddr_q;
    end

    // Fetch FSM: fetch_pc, external handshake registers, local inflight flag
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= RUN;
            fetch_pc_q <= PC_INIT;
            go_q       <= 1'b0;
            inflight_q <= 1'b0;
            exren_q    <= 1'b0;
            exaddr_q   <= EX_IDLE;
        end else begin
            go_q       <= 1'b1;
            inflight_q <= issue_local;
            case (state_q)
                RUN: begin
                    if (br_en) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (issue_local) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end else if (start_ext) begin
                        state_q  <= EXWAIT;
                        exren_q  <= 1'b1;
                        exaddr_q <= ex_target;
                    end
                end
                EXWAIT: begin
                    if (exIns_valid) begin
                        // Either accepted or, under a redirect, dropped.
                        state_q    <= RUN;
                        exren_q    <= 1'b0;
                        exaddr_q   <= EX_IDLE;
                        fetch_pc_q <= br_en ? redirect_pc : fetch_pc_q + 32'd4;
                    end else if (br_en) begin
                        // The request already on the bus must complete before
                        // fetching resumes; its data will be thrown away.
                        state_q    <= EXDRAIN;
                        fetch_pc_q <= redirect_pc;
                    end
                end
                EXDRAIN: begin
                    if (br_en) begin
                        fetch_pc_q <= redirect_pc;
                    end
                    if (exIns_valid) begin
                        state_q  <= RUN;
                        exren_q  <= 1'b0;
                        exaddr_q <= EX_IDLE;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    exren_q  <= 1'b0;
                    exaddr_q <= EX_IDLE;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk) begin
        if (!nrst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (br_en) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue payload and local read address capture (datapath, no reset)
    always_ff @(posedge clk) begin
        if (push) begin
            pc_arr[tail_q]  <= push_pc;
            ins_arr[tail_q] <= push_ins;
        end
        if (issue_local) begin
            lpc_q <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: scoreboard of expected {pc, ins} entries
// consumed whenever the DUT pops its head, plus point checks on fetch ports.
module tb_ifetch_queue;

    logic        clk;
    logic        nrst;
    logic        stall;
    logic        br_en;
    logic [31:0] br_addr;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        imem_ren;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        exIns_ren;
    logic [31:0] exIns_addr;
    logic        exIns_valid;
    logic [31:0] exIns_in;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t sb[$];
    int   checks;
    int   failures;

    ifetch_queue #(
        .PC_INIT    (32'h0000_00fc),
        .IMEM_AWIDTH(11),
        .QDEPTH     (4)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .stall      (stall),
        .br_en      (br_en),
        .br_addr    (br_addr),
        .ins_valid  (ins_valid),
        .ins_out    (ins_out),
        .ins_pc     (ins_pc),
        .imem_ren   (imem_ren),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .exIns_ren  (exIns_ren),
        .exIns_addr (exIns_addr),
        .exIns_valid(exIns_valid),
        .exIns_in   (exIns_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IMEM model: returns the byte address as the instruction word.
    always @(posedge clk) begin
        imem_rdata <= imem_ren ? 32'(imem_addr) : 32'hdead_beef;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({start + 32'(4 * i), start + 32'(4 * i)});
        end
    endtask

    // Scoreboard consumer: every pop the DUT performs must match the next expected entry.
    always @(negedge clk) begin
        if (nrst === 1'b1 && ins_valid === 1'b1 && stall === 1'b0 && br_en === 1'b0) begin
            checks++;
            assert (sb.size() != 0)
            else begin
                failures++;
                $error("FAIL pop_unexpected observed_pc=%h expected=none", ins_pc);
            end
            if (sb.size() != 0) begin
                ent_t e;
                e = sb.pop_front();
                chk("pop_pc", ins_pc, e.pc);
                chk("pop_ins", ins_out, e.ins);
            end
        end
    end

    initial begin
        checks      = 0;
        failures    = 0;
        nrst        = 1'b0;
        stall       = 1'b0;
        br_en       = 1'b0;
        br_addr     = 32'd0;
        exIns_valid = 1'b0;
        exIns_in    = 32'd0;

        // Reset state
        nxt();
        nxt();
        smp();
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins_out", ins_out, 32'd0);
        chk("rst_ins_pc", ins_pc, 32'd0);
        chk("rst_imem_ren", 32'(imem_ren), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_exIns_ren", 32'(exIns_ren), 32'd0);
        chk("rst_exIns_addr", exIns_addr, 32'hffff_ffff);

        // Release reset, free-running local fetch
        nxt();
        nrst = 1'b1;
        push_run(32'h0000_00fc, 40);
        smp();
        chk("boot_imem_ren", 32'(imem_ren), 32'd0);
        nxt(); smp();
        chk("c0_imem_ren", 32'(imem_ren), 32'd1);
        chk("c0_imem_addr", 32'(imem_addr), 32'h0fc);
        chk("c0_ins_valid", 32'(ins_valid), 32'd0);
        nxt(); smp();
        chk("c1_imem_addr", 32'(imem_addr), 32'h100);
        chk("c1_ins_valid", 32'(ins_valid), 32'd0);
        nxt(); smp();
        chk("c2_ins_valid", 32'(ins_valid), 32'd1);
        chk("c2_ins_pc", ins_pc, 32'h0fc);
        nxt(); smp();
        chk("c3_ins_pc", ins_pc, 32'h100);

        // Stall 10 cycles: queue fills, fetch stops, head holds
        nxt();
        stall = 1'b1;
        smp();
        chk("stall_head", ins_pc, 32'h104);
        for (int i = 0; i < 9; i++) begin
            nxt(); smp();
            chk("stall_head", ins_pc, 32'h104);
            if (i >= 2) chk("stall_full_noren", 32'(imem_ren), 32'd0);
        end
        nxt();
        stall = 1'b0;
        smp();
        chk("release_valid", 32'(ins_valid), 32'd1);
        for (int i = 0; i < 7; i++) begin
            nxt(); smp();
            chk("release_valid", 32'(ins_valid), 32'd1);
        end

        // Redirect to 0x7fb: two local words then crossing into external space
        nxt();
        br_en   = 1'b1;
        br_addr = 32'h0000_07fb;
        sb.delete();
        push_run(32'h0000_07f8, 2);
        sb.push_back({32'h0000_0800, 32'he000_0800});
        smp();
        chk("br_suppress_issue", 32'(imem_ren), 32'd0);
        nxt();
        br_en = 1'b0;
        smp();
        chk("br_flush_empty", 32'(ins_valid), 32'd0);
        chk("br_first_ren", 32'(imem_ren), 32'd1);
        chk("br_first_addr", 32'(imem_addr), 32'h7f8);
        nxt(); smp();
        chk("br_second_addr", 32'(imem_addr), 32'h7fc);
        nxt(); smp();
        chk("cross_no_imem", 32'(imem_ren), 32'd0);
        chk("cross_wait_inflight", 32'(exIns_ren), 32'd0);
        nxt(); smp();
        chk("cross_enter", 32'(exIns_ren), 32'd0);
        nxt(); smp();
        chk("ex_ren", 32'(exIns_ren), 32'd1);
        chk("ex_addr", exIns_addr, 32'd0);
        nxt(); nxt();
        nxt();
        exIns_valid = 1'b1;
        exIns_in    = 32'he000_0800;
        smp();
        chk("ex_ren_held", 32'(exIns_ren), 32'd1);
        chk("ex_addr_held", exIns_addr, 32'd0);
        nxt();
        exIns_valid = 1'b0;
        smp();
        chk("ex_ren_drop", 32'(exIns_ren), 32'd0);
        chk("ex_addr_idle", exIns_addr, 32'hffff_ffff);
        nxt(); smp();
        chk("ex2_ren", 32'(exIns_ren), 32'd1);
        chk("ex2_addr", exIns_addr, 32'd4);

        // Redirect to 0x500 while waiting externally: drain, drop data
        nxt();
        br_en   = 1'b1;
        br_addr = 32'h0000_0500;
        sb.delete();
        push_run(32'h0000_0500, 20);
        smp();
        nxt();
        br_en = 1'b0;
        smp();
        chk("drain_ren", 32'(exIns_ren), 32'd1);
        chk("drain_addr", exIns_addr, 32'd4);
        chk("drain_no_imem", 32'(imem_ren), 32'd0);
        chk("drain_empty", 32'(ins_valid), 32'd0);
        nxt();
        exIns_valid = 1'b1;
        exIns_in    = 32'hbad0_bad0;
        smp();
        chk("drain_empty2", 32'(ins_valid), 32'd0);
        nxt();
        exIns_valid = 1'b0;
        smp();
        chk("drain_done_ren", 32'(exIns_ren), 32'd0);
        chk("drain_resume_addr", 32'(imem_addr), 32'h500);
        nxt(); smp();
        chk("drain_empty3", 32'(ins_valid), 32'd0);
        nxt(); smp();
        chk("drain_first_pc", ins_pc, 32'h500);
        for (int i = 0; i < 4; i++) nxt();

        // Fill the queue, then redirect with stall released
        nxt();
        stall = 1'b1;
        for (int i = 0; i < 7; i++) nxt();
        smp();
        chk("fill_noren", 32'(imem_ren), 32'd0);
        chk("fill_valid", 32'(ins_valid), 32'd1);
        nxt();
        stall   = 1'b0;
        br_en   = 1'b1;
        br_addr = 32'h0000_0200;
        sb.delete();
        push_run(32'h0000_0200, 10);
        smp();
        nxt();
        br_en = 1'b0;
        smp();
        chk("fullbr_empty", 32'(ins_valid), 32'd0);
        chk("fullbr_addr", 32'(imem_addr), 32'h200);
        nxt(); smp();
        chk("fullbr_empty2", 32'(ins_valid), 32'd0);
        nxt(); smp();
        chk("fullbr_first_pc", ins_pc, 32'h200);
        for (int i = 0; i < 3; i++) nxt();

        // Redirect straight to external space, then reset mid-wait
        nxt();
        br_en   = 1'b1;
        br_addr = 32'h0000_0802;
        sb.delete();
        smp();
        nxt();
        br_en = 1'b0;
        smp();
        chk("ext_direct_noren", 32'(exIns_ren), 32'd0);
        chk("ext_direct_noimem", 32'(imem_ren), 32'd0);
        nxt(); smp();
        chk("ext_direct_ren", 32'(exIns_ren), 32'd1);
        chk("ext_direct_addr", exIns_addr, 32'd0);
        nxt();
        nrst = 1'b0;
        smp();
        nxt();
        nrst        = 1'b1;
        exIns_valid = 1'b1;
        exIns_in    = 32'hdead_dead;
        sb.delete();
        push_run(32'h0000_00fc, 6);
        smp();
        chk("rst_ex_ren", 32'(exIns_ren), 32'd0);
        chk("rst_ex_addr", exIns_addr, 32'hffff_ffff);
        chk("rst_ex_noimem", 32'(imem_ren), 32'd0);
        nxt(); smp();
        chk("refetch_addr", 32'(imem_addr), 32'h0fc);
        chk("refetch_noexren", 32'(exIns_ren), 32'd0);
        nxt();
        exIns_valid = 1'b0;
        smp();
        chk("refetch_empty", 32'(ins_valid), 32'd0);
        nxt(); smp();
        chk("refetch_pc", ins_pc, 32'h0fc);
        chk("refetch_ins", ins_out, 32'h0fc);
        for (int i = 0; i < 3; i++) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
